// File: rtl/eth_udp_frame_builder.sv
// Builds one 526-byte Ethernet/IPv4/UDP frame in BRAM, then hands it to the transmitter.
// Optional UDP checksum generation: define ETH_UDP_CSUM_EN.
module eth_udp_frame_builder #(
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC  = 48'h020000000002,
    parameter logic [31:0] SRC_IP   = 32'h0A000002,
    parameter logic [31:0] DST_IP   = 32'h0A000001,
    parameter logic [15:0] SRC_PORT = 16'h04D2,
    parameter logic [15:0] DST_PORT = 16'h04D2,
    parameter logic [7:0]  TTL      = 8'h40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       bram_wr_en,
    output logic [9:0] bram_wr_addr,
    output logic [7:0] bram_wr_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       frame_sent
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ICSUM = 4'd1;
    localparam logic [3:0] S_IFOLD = 4'd2;
    localparam logic [3:0] S_HDR   = 4'd3;
    localparam logic [3:0] S_PAY   = 4'd4;
`ifdef ETH_UDP_CSUM_EN
    localparam logic [3:0] S_UFOLD = 4'd5;
    localparam logic [3:0] S_UWR   = 4'd6;
`endif
    localparam logic [3:0] S_START = 4'd7;
    localparam logic [3:0] S_WAIT  = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [15:0] ident_q, ident_d;
    logic [19:0] iacc_q, iacc_d;
    logic [15:0] icsum_q, icsum_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        tx_start_q, tx_start_d;
    logic        sent_q, sent_d;
    logic [335:0] hdr_w;

    function automatic logic [15:0] fold24(input logic [23:0] s);
        logic [23:0] t;
        t = {8'h00, s[15:0]} + {16'h0000, s[23:16]};
        t = {8'h00, t[15:0]} + {16'h0000, t[23:16]};
        return t[15:0];
    endfunction

    function automatic logic [15:0] ip_word(input logic [3:0] i,
                                            input logic [15:0] id);
        logic [15:0] w;
        case (i)
            4'd0:    w = 16'h4500;
            4'd1:    w = 16'h0200;
            4'd2:    w = id;
            4'd4:    w = {TTL, 8'h11};
            4'd6:    w = SRC_IP[31:16];
            4'd7:    w = SRC_IP[15:0];
            4'd8:    w = DST_IP[31:16];
            4'd9:    w = DST_IP[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // UDP checksum field is written as zero here; UWR overwrites it when enabled.
    assign hdr_w = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, 16'h0200,
                    ident_q, 16'h0000, TTL, 8'h11, icsum_q, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, 16'h01EC, 16'h0000};

`ifdef ETH_UDP_CSUM_EN
    localparam logic [23:0] UDP_INIT =
        {8'h00, SRC_IP[31:16]} + {8'h00, SRC_IP[15:0]} +
        {8'h00, DST_IP[31:16]} + {8'h00, DST_IP[15:0]} +
        24'h000011 + 24'h0001EC + 24'h0001EC +
        {8'h00, SRC_PORT} + {8'h00, DST_PORT};

    logic [23:0] uacc_q, uacc_d;
    logic [15:0] ucsum_q, ucsum_d;
    logic [15:0] ufold;

    assign ufold = ~fold24(uacc_q);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ident_d    = ident_q;
        iacc_d     = iacc_q;
        icsum_d    = icsum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        tx_start_d = 1'b0;
        sent_d     = 1'b0;
        s_ready    = 1'b0;
`ifdef ETH_UDP_CSUM_EN
        uacc_d     = uacc_q;
        ucsum_d    = ucsum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_ICSUM;
                    cnt_d   = 10'd0;
                    iacc_d  = 20'd0;
`ifdef ETH_UDP_CSUM_EN
                    uacc_d  = UDP_INIT;
`endif
                end
            end
            S_ICSUM: begin
                iacc_d = iacc_q + {4'h0, ip_word(cnt_q[3:0], ident_q)};
                cnt_d  = cnt_q + 10'd1;
                if (cnt_q == 10'd9) begin
                    state_d = S_IFOLD;
                    cnt_d   = 10'd0;
                end
            end
            S_IFOLD: begin
                icsum_d = ~fold24({4'h0, iacc_q});
                state_d = S_HDR;
            end
            S_HDR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = hdr_w[(335 - 8 * int'(cnt_q)) -: 8];
                cnt_d     = cnt_q + 10'd1;
                if (cnt_q == 10'd41) begin
                    state_d = S_PAY;
                    cnt_d   = 10'd0;
                end
            end
            S_PAY: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 10'd42 + cnt_q;
                    wr_data_d = s_data;
                    cnt_d     = cnt_q + 10'd1;
`ifdef ETH_UDP_CSUM_EN
                    uacc_d = uacc_q + (cnt_q[0] ? {16'h0000, s_data}
                                                : {8'h00, s_data, 8'h00});
`endif
                    if (cnt_q == 10'd483) begin
                        cnt_d = 10'd0;
`ifdef ETH_UDP_CSUM_EN
                        state_d = S_UFOLD;
`else
                        state_d = S_START;
`endif
                    end
                end
            end
`ifdef ETH_UDP_CSUM_EN
            S_UFOLD: begin
                ucsum_d = (ufold == 16'h0000) ? 16'hFFFF : ufold;
                state_d = S_UWR;
            end
            S_UWR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = 10'd40 + cnt_q;
                wr_data_d = cnt_q[0] ? ucsum_q[7:0] : ucsum_q[15:8];
                cnt_d     = cnt_q + 10'd1;
                // Raise start alongside the final checksum byte.
                if (cnt_q == 10'd1) begin
                    cnt_d      = 10'd0;
                    state_d    = S_START;
                    tx_start_d = ~tx_busy;
                end
            end
`endif
            S_START: begin
                tx_start_d = ~tx_busy;
                if (tx_busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    sent_d  = 1'b1;
                    ident_d = ident_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 10'd0;
            ident_q    <= 16'd0;
            iacc_q     <= 20'd0;
            icsum_q    <= 16'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 10'd0;
            wr_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ident_q    <= ident_d;
            iacc_q     <= iacc_d;
            icsum_q    <= icsum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tx_start_q <= tx_start_d;
            sent_q     <= sent_d;
        end
    end

`ifdef ETH_UDP_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uacc_q  <= 24'd0;
            ucsum_q <= 16'd0;
        end else begin
            uacc_q  <= uacc_d;
            ucsum_q <= ucsum_d;
        end
    end
`endif

    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign tx_start     = tx_start_q;
    assign frame_sent   = sent_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_udp_frame_builder.sv
// Directed bench for eth_udp_frame_builder: BRAM image, handshake timing, reset abort.
module tb_eth_udp_frame_builder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       bram_wr_en;
    logic [9:0] bram_wr_addr;
    logic [7:0] bram_wr_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       frame_sent;

    always #5 clk = ~clk;

    eth_udp_frame_builder dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .bram_wr_en(bram_wr_en),
        .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
        .frame_sent(frame_sent)
    );

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } vec_t;

`ifdef ETH_UDP_CSUM_EN
    localparam int START_LAT = 3;
    localparam int NWR = 528;
`else
    localparam int START_LAT = 1;
    localparam int NWR = 526;
`endif

    int nvec = 0;
    int nbad = 0;

    logic [7:0] mem [1024];
    logic [7:0] pay [484];
    logic [7:0] base [42] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
        8'h08, 8'h00, 8'h45, 8'h00, 8'h02, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11,
        8'h64, 8'hEB, 8'h0A, 8'h00, 8'h00, 8'h02,
        8'h0A, 8'h00, 8'h00, 8'h01, 8'h04, 8'hD2,
        8'h04, 8'hD2, 8'h01, 8'hEC, 8'h00, 8'h00};

    // BRAM model plus write statistics
    logic clr = 1'b0;
    int   nwr, pay_err, busy_wr, first_addr, nxt_pay;
    always @(posedge clk) begin
        if (clr) begin
            nwr <= 0; pay_err <= 0; busy_wr <= 0;
            first_addr <= -1; nxt_pay <= 42;
        end else if (bram_wr_en) begin
            mem[bram_wr_addr] <= bram_wr_data;
            nwr <= nwr + 1;
            if (nwr == 0) first_addr <= int'(bram_wr_addr);
            if (tx_busy) busy_wr <= busy_wr + 1;
            if (bram_wr_addr >= 10'd42) begin
                if (int'(bram_wr_addr) != nxt_pay) pay_err <= pay_err + 1;
                nxt_pay <= int'(bram_wr_addr) + 1;
            end
        end
    end

    // Transmitter model: busy 5 cycles after start, for 1000 cycles
    int rc, fc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0; rc <= 0; fc <= 0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                if (rc == 4) begin
                    tx_busy <= 1'b1; rc <= 0; fc <= 0;
                end else rc <= rc + 1;
            end else rc <= 0;
        end else begin
            if (fc == 999) tx_busy <= 1'b0;
            else fc <= fc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] udp_model();
        logic [31:0] s;
        s = 32'h0A00 + 32'h0002 + 32'h0A00 + 32'h0001 + 32'h0011 +
            32'h01EC + 32'h01EC + 32'h04D2 + 32'h04D2;
        for (int i = 0; i < 484; i += 2)
            s = s + {16'h0, pay[i], pay[i+1]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s[15:0] = ~s[15:0];
        return (s[15:0] == 16'h0) ? 16'hFFFF : s[15:0];
    endfunction

    task automatic clear_stats();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic run_payload(input bit gappy, input int abort_at,
                               output bit aborted);
        int  k = 0;
        int  guard = 0;
        bit  beat;
        aborted = 1'b0;
        s_valid = 1'b1;
        s_data  = pay[0];
        while (k < 484 && guard < 4000) begin
            @(negedge clk);
            beat = s_valid && s_ready;
            @(posedge clk);
            #1;
            guard++;
            if (beat) k++;
            if (abort_at >= 0 && k == abort_at) begin
                aborted = 1'b1;
                break;
            end
            s_data  = (k < 484) ? pay[k] : 8'h00;
            s_valid = (k >= 484) ? 1'b0 : (gappy ? ~s_valid : 1'b1);
        end
        if (!aborted && k < 484) chk("payload_beats", k, 484);
        s_valid = 1'b0;
    endtask

    task automatic check_tx();
        int last_pay = -1, first_ts = -1, rise = -1, fall = -1;
        int fs_cyc = -1, fs_n = 0, sr_hi = 0;
        bit prev_tb = 1'b0, ts_rise = 1'b0, ts_after = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (bram_wr_en && bram_wr_addr == 10'd525) last_pay = cyc;
            if (tx_start && first_ts < 0) first_ts = cyc;
            if (tx_busy && !prev_tb) begin rise = cyc; ts_rise = tx_start; end
            if (rise >= 0 && cyc == rise + 1) ts_after = tx_start;
            if (!tx_busy && prev_tb) fall = cyc;
            if (frame_sent) begin fs_n++; fs_cyc = cyc; end
            if (s_ready) sr_hi++;
            prev_tb = tx_busy;
            if (fs_n > 0 && cyc > fs_cyc + 3) break;
        end
        chk("start_latency", first_ts - last_pay, START_LAT);
        chk("start_at_busy_rise", ts_rise, 1);
        chk("start_drop", ts_after, 0);
        chk("frame_sent_count", fs_n, 1);
        chk("frame_sent_time", fs_cyc - fall, 1);
        chk("s_ready_low", sr_hi, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_frame(input logic [15:0] id, input logic [15:0] cs,
                               input logic [15:0] uc, input bit chk_udp);
        vec_t vt [44];
        for (int i = 0; i < 42; i++) begin
            vt[i].addr = i;
            vt[i].exp  = base[i];
        end
        vt[18].exp = id[15:8];  vt[19].exp = id[7:0];
        vt[24].exp = cs[15:8];  vt[25].exp = cs[7:0];
        vt[40].exp = uc[15:8];  vt[41].exp = uc[7:0];
        vt[42].addr = 42;  vt[42].exp = pay[0];
        vt[43].addr = 525; vt[43].exp = pay[483];
        for (int i = 0; i < 44; i++)
            if (chk_udp || (vt[i].addr != 40 && vt[i].addr != 41))
                chk($sformatf("bram[%0d]", vt[i].addr),
                    mem[vt[i].addr], vt[i].exp);
        chk("write_count", nwr, NWR);
        chk("payload_contiguous", pay_err, 0);
        chk("payload_end", nxt_pay, 526);
        chk("write_while_busy", busy_wr, 0);
        chk("first_addr", first_addr, 0);
    endtask

    initial begin
        bit ab;
        int bad;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", bram_wr_en, 0);
        chk("rst_wr_addr", bram_wr_addr, 0);
        chk("rst_wr_data", bram_wr_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_sent", frame_sent, 0);
        chk("rst_s_ready", s_ready, 0);
        @(negedge clk) rst_n = 1'b1;

        // Frame A: ident 0, zero payload
        for (int i = 0; i < 484; i++) pay[i] = 8'h00;
        clear_stats();
        run_payload(1'b0, -1, ab);
        check_tx();
`ifdef ETH_UDP_CSUM_EN
        check_frame(16'h0000, 16'h64EB, 16'hDE6F, 1'b1);
`else
        check_frame(16'h0000, 16'h64EB, 16'h0000, 1'b1);
`endif

        // Frame B: ident 1, first byte 0x01, s_valid toggling
        pay[0] = 8'h01;
        clear_stats();
        run_payload(1'b1, -1, ab);
        check_tx();
`ifdef ETH_UDP_CSUM_EN
        check_frame(16'h0001, 16'h64EA, 16'hDD6F, 1'b1);
`else
        check_frame(16'h0001, 16'h64EA, 16'h0000, 1'b1);
`endif

        // Frame C: reset at payload beat 100
        for (int i = 0; i < 484; i++) pay[i] = 8'(i * 7 + 3);
        clear_stats();
        run_payload(1'b0, 100, ab);
        chk("abort_reached", ab, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", bram_wr_en, 0);
        chk("abort_tx_start", tx_start, 0);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Frame D: clean restart, ident back to 0
        clear_stats();
        run_payload(1'b0, -1, ab);
        check_tx();
`ifdef ETH_UDP_CSUM_EN
        check_frame(16'h0000, 16'h64EB, udp_model(), 1'b1);
`else
        check_frame(16'h0000, 16'h64EB, 16'h0000, 1'b1);
`endif
        bad = 0;
        for (int i = 0; i < 484; i++)
            if (mem[42 + i] !== pay[i]) bad++;
        chk("payload_data", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/eth_udp_frame_builder.md
# eth_udp_frame_builder

Upstream stage of the 10BASE-T transmitter. It takes a 484-byte payload stream and writes one complete 526-byte Ethernet/IPv4/UDP frame into the shared frame BRAM at addresses 0..525. The frame excludes preamble, SFD and FCS, which the transmitter adds. It then hands the buffer to the transmitter through the start/tx_busy handshake and waits for transmission to finish before building the next frame.

## Interface
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC
- SRC_MAC, 48'h020000000002, source MAC
- SRC_IP, 32'h0A000002, source IPv4
- DST_IP, 32'h0A000001, destination IPv4
- SRC_PORT, 16'h04D2, UDP source port
- DST_PORT, 16'h04D2, UDP destination port
- TTL, 8'h40, IPv4 TTL
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_ready  out  1  builder accepts byte (beat = s_valid & s_ready)
- bram_wr_en  out  1  BRAM write strobe
- bram_wr_addr  out  10  BRAM write address
- bram_wr_data  out  8  BRAM write data
- tx_start  out  1  to transmitter `start`
- tx_busy  in  1  from transmitter
- busy  out  1  high whenever state != IDLE
- frame_sent  out  1  one-cycle pulse when the transmitter finishes a frame

## Operation
- Frame layout (big-endian):
  - 0-5: DST_MAC
  - 6-11: SRC_MAC
  - 12-13: 0x0800
  - 14: 0x45
  - 15: 0x00
  - 16-17: total length 0x0200
  - 18-19: ident
  - 20-21: 0x0000
  - 22: TTL
  - 23: 0x11
  - 24-25: IP checksum
  - 26-29: SRC_IP
  - 30-33: DST_IP
  - 34-35: SRC_PORT
  - 36-37: DST_PORT
  - 38-39: UDP length 0x01EC
  - 40-41: UDP checksum
  - 42-525: payload
- ident is a 16-bit register, 0 after reset. It increments by 1 on each frame_sent and wraps 0xFFFF to 0x0000.
- States and transitions:
  - IDLE: go to ICSUM when s_valid=1.
  - ICSUM: sum the 10 IPv4 header words, with the checksum field as 0, into a 20-bit accumulator at one word per cycle.
  - IFOLD: add carries into the low 16 bits twice, then invert.
  - HDR: write bytes 0..41, one per cycle, with 40-41 written as 0x00.
  - PAYLOAD: s_ready=1. Each beat writes s_data to address 42+k. After 484 beats go to UCSUM if the macro is defined, otherwise to START.
  - UCSUM: the macro's states; see Configuration.
  - START: hold tx_start=1 until tx_busy=1, then go to WAIT.
  - WAIT: tx_start=0. When tx_busy=0, pulse frame_sent, increment ident and go to IDLE.
- tx_start is held level rather than pulsed, because the transmitter samples only on its clock-enable ticks.
- s_ready=0 in every state except PAYLOAD. Gaps in s_valid stall PAYLOAD indefinitely and write nothing.
- The BRAM is never written while tx_busy=1.

## Timing
- Reset values: all outputs 0, state IDLE, ident 0, accumulators 0.
- Asserting rst_n=0 mid-frame aborts immediately: bram_wr_en and tx_start drop asynchronously, and a partial frame is left in the BRAM untouched.
- Latency with s_valid held high:
  - ICSUM takes 10 cycles, IFOLD takes 1, HDR takes 42, PAYLOAD takes 484.
  - The first payload write happens 53 cycles after IDLE exits.
  - tx_start rises the cycle after the last payload write (3 cycles later with the macro).
- Write port: registered. bram_wr_en, bram_wr_addr and bram_wr_data change together, one byte per cycle maximum.
- Arithmetic is ones'-complement. Fold: sum = sum[15:0] + sum[19:16], applied twice.
- If tx_busy is already 1 on entry to START, the builder moves to WAIT the next cycle.

## Configuration
- ETH_UDP_CSUM_EN:
  - Defined:
    - A 24-bit accumulator starts from the pseudo-header plus UDP header sum: SRC_IP, DST_IP, 0x0011, 0x01EC twice, SRC_PORT, DST_PORT.
    - During PAYLOAD it adds each byte pair: even offset as the high byte, odd offset as the low byte.
    - After the payload, UFOLD (1 cycle) folds and inverts the sum, and a result of 0x0000 becomes 0xFFFF.
    - UWR (2 cycles) writes the high byte to address 40 and the low byte to address 41.
  - Undefined: no accumulator and no UFOLD/UWR states. Addresses 40-41 stay 0x0000, which means no UDP checksum.

## Test plan
- Default parameters, ident 0, zero payload -> BRAM[24]=0x64, BRAM[25]=0xEB; BRAM[12..13]=0x08,0x00; BRAM[16..17]=0x02,0x00.
- Second frame after frame_sent -> BRAM[18..19]=0x00,0x01 and checksum 0x64EA; ident 0xFFFF -> next frame carries 0x0000.
- With ETH_UDP_CSUM_EN: zero payload -> BRAM[40..41]=0xDE,0x6F; payload byte 0 = 0x01, rest 0 -> 0xDD,0x6F. Without the macro -> 0x00,0x00 in both cases.
- s_valid toggled every other cycle during PAYLOAD -> exactly 484 writes, addresses 42..525 contiguous, no write while s_valid=0.
- tx_busy model rises 5 cycles after tx_start and falls 1000 cycles later:
  - tx_start drops the cycle after tx_busy rises.
  - frame_sent pulses once, the cycle after tx_busy falls.
  - s_ready stays 0 throughout.
- rst_n pulsed low at payload beat 100 -> bram_wr_en=0, tx_start=0, busy=0 and ident=0 immediately; the next frame starts cleanly from address 0.
